// File: rtl/wimax_interleaver_pp_pkg.sv
// wimax_interleaver_pp_pkg: shared bank-state type and default geometry for the 802.16 ping-pong interleaver
package wimax_interleaver_pp_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;
  localparam int unsigned DEF_N_CBPS = 192;
  localparam int unsigned DEF_D = 16;
  localparam int unsigned DEF_S = 1;
  function automatic logic writable(bank_state_t st);
    return st == EMPTY || st == FILLING;
  endfunction
  function automatic logic holds_data(bank_state_t st);
    return st == FULL || st == DRAINING;
  endfunction
endpackage

// File: rtl/wimax_interleaver_pp_addr_gen.sv
// intlv_addr_gen: multiplier-free col/row/mk counter producing the 802.16 permuted write address jk
module intlv_addr_gen
  import wimax_interleaver_pp_pkg::*;
#(
  parameter int unsigned N_CBPS = DEF_N_CBPS,
  parameter int unsigned D = DEF_D,
  parameter int unsigned S = DEF_S,
  parameter int unsigned AW = $clog2(N_CBPS)
) (
  input  logic          clk,
  input  logic          reset_N,
  input  logic          start,
  input  logic          advance,
  input  logic          identity,
  output logic [AW-1:0] wr_addr,
  output logic          last
);
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [AW-1:0] ROWS = AW'(N_CBPS / D);
  localparam logic [AW-1:0] SMASK = AW'(S - 1);
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] row_q, row_d, mk_q, mk_d, k_q, k_d, diff, jk;
  logic id_q, id_d, wrap, first, use_id;
  assign first = k_q == '0;
  assign last = k_q == AW'(N_CBPS - 1);
  assign diff = mk_q - AW'(col_q);
  assign jk = (mk_q & ~SMASK) | (diff & SMASK);
  assign use_id = first ? identity : id_q;
  assign wr_addr = use_id ? k_q : jk;
  // step the counters one bit per advance; start clears them for the next block
  always_comb begin
    wrap = col_q == CW'(D - 1);
    k_d = start ? '0 : advance ? k_q + 1'b1 : k_q;
    col_d = start ? '0 : advance ? (wrap ? '0 : col_q + 1'b1) : col_q;
    row_d = start ? '0 : (advance & wrap) ? row_q + 1'b1 : row_q;
    mk_d = start ? '0 : advance ? (wrap ? row_q + 1'b1 : mk_q + ROWS) : mk_q;
    id_d = (advance & first) ? identity : id_q;
  end
  // counter and identity-mode registers
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      col_q <= '0;
      row_q <= '0;
      mk_q <= '0;
      k_q <= '0;
      id_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      mk_q <= mk_d;
      k_q <= k_d;
      id_q <= id_d;
    end
  end
endmodule

// File: rtl/wimax_interleaver_pp.sv
// wimax_interleaver_pp: 802.16 block interleaver with two ping-pong banks; optional INTERLEAVER_BYPASS_EN adds an identity-order bypass port
module wimax_interleaver_pp
  import wimax_interleaver_pp_pkg::*;
#(
  parameter int unsigned N_CBPS = DEF_N_CBPS,
  parameter int unsigned D = DEF_D,
  parameter int unsigned S = DEF_S,
  parameter int unsigned AW = $clog2(N_CBPS)
) (
  input  logic clk,
  input  logic reset_N,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
`ifdef INTERLEAVER_BYPASS_EN
  input  logic bypass,
`endif
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
);
  localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);
  bank_state_t st_q [2];
  bank_state_t st_d [2];
  logic [N_CBPS-1:0] mem_q [2];
  logic [N_CBPS-1:0] mem_d [2];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d, wr_addr;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic out_bit_q, out_bit_d, out_last_q, out_last_d;
  logic wr_fire, wr_last, rd_fire, rd_last, identity;
`ifdef INTERLEAVER_BYPASS_EN
  assign identity = bypass;
`else
  assign identity = 1'b0;
`endif
  assign wr_fire = in_valid & in_ready_q;
  assign rd_fire = out_valid_q & out_ready;
  assign rd_last = rd_addr_q == LAST;
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit = out_bit_q;
  assign out_last = out_last_q;
  intlv_addr_gen #(
    .N_CBPS(N_CBPS),
    .D(D),
    .S(S),
    .AW(AW)
  ) u_addr_gen (
    .clk(clk),
    .reset_N(reset_N),
    .start(wr_fire & wr_last),
    .advance(wr_fire),
    .identity(identity),
    .wr_addr(wr_addr),
    .last(wr_last)
  );
  // bank bookkeeping; the read stage looks at next-cycle memory so a just-completed bank is presented with no extra bubble
  always_comb begin
    st_d = st_q;
    mem_d = mem_q;
    if (wr_fire) begin
      mem_d[wr_bank_q][wr_addr] = in_bit;
      st_d[wr_bank_q] = wr_last ? FULL : FILLING;
    end
    if (rd_fire) st_d[rd_bank_q] = rd_last ? EMPTY : DRAINING;
    wr_bank_d = wr_bank_q ^ (wr_fire & wr_last);
    rd_bank_d = rd_bank_q ^ (rd_fire & rd_last);
    rd_addr_d = rd_fire ? (rd_last ? '0 : rd_addr_q + 1'b1) : rd_addr_q;
    in_ready_d = writable(st_d[wr_bank_d]);
    out_valid_d = holds_data(st_d[rd_bank_d]);
    out_bit_d = mem_d[rd_bank_d][rd_addr_d];
    out_last_d = out_valid_d & (rd_addr_d == LAST);
  end
  // storage, bank pointers and registered handshake outputs
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      st_q <= '{EMPTY, EMPTY};
      mem_q <= '{default: '0};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      mem_q <= mem_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_wimax_interleaver_pp.sv
// tb_wimax_interleaver_pp: scoreboard bench for the ping-pong interleaver (QPSK 192/16/1 and 16-QAM 384/16/2 instances)
module tb_wimax_interleaver_pp;
  localparam int NA = 192, DA = 16, SA = 1;
  localparam int NB = 384, DB = 16, SB = 2;
  logic clk = 0;
  logic reset_N = 1;
  logic iv [2];
  logic ib [2];
  logic ordy [2];
  logic ir [2];
  logic ov [2];
  logic ob [2];
  logic ol [2];
`ifdef INTERLEAVER_BYPASS_EN
  logic byp = 0;
`endif
  logic [1:0] qa [$];
  logic [1:0] qb [$];
  int rmode [2];
  int acc [2];
  int n_cmp = 0, n_bad = 0, cyc = 0, last_fire_cyc = 0, pp_first = -1, pp_last = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wimax_interleaver_pp u_a (
    .clk(clk), .reset_N(reset_N), .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]),
`ifdef INTERLEAVER_BYPASS_EN
    .bypass(byp),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]), .out_last(ol[0])
  );
  wimax_interleaver_pp #(.N_CBPS(NB), .D(DB), .S(SB)) u_b (
    .clk(clk), .reset_N(reset_N), .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(ib[1]),
`ifdef INTERLEAVER_BYPASS_EN
    .bypass(1'b0),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_bit(ob[1]), .out_last(ol[1])
  );

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // textbook 802.16 two-step permutation: k -> mk -> jk
  function automatic logic [383:0] ref_out(int n, int d, int s, logic [383:0] din, bit byp_in);
    logic [383:0] r = '0;
    for (int k = 0; k < n; k++) begin
      int mk = (n / d) * (k % d) + k / d;
      int jk = s * (mk / s) + (mk + n - (d * mk) / n) % s;
      r[byp_in ? k : jk] = din[k];
    end
    return r;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic send(int s, logic [383:0] din, int gap, bit byp_in, int stop_at);
    int n = (s == 0) ? NA : NB;
    logic [383:0] r = ref_out(n, (s == 0) ? DA : DB, (s == 0) ? SA : SB, din, byp_in);
    if (stop_at == n)
      for (int j = 0; j < n; j++)
        if (s == 0) qa.push_back({r[j], 1'(j == n - 1)});
        else qb.push_back({r[j], 1'(j == n - 1)});
    for (int k = 0; k < stop_at; k++) begin
      int tries = 0;
      do begin
        @(negedge clk);
        iv[s] = ($urandom_range(0, 99) >= gap);
        ib[s] = din[k];
`ifdef INTERLEAVER_BYPASS_EN
        if (s == 0) byp = (k == 0) ? byp_in : ~byp_in;
`endif
        if (++tries > 20000) begin
          $display("FAIL drive_timeout: dut %0d stuck at k=%0d", s, k);
          n_bad++;
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $fatal(1);
        end
      end while (!(iv[s] && ir[s]));
      acc[s]++;
      last_fire_cyc = cyc;
    end
  endtask

  task automatic idle(int s);
    @(negedge clk);
    iv[s] = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6000 && (qa.size() + qb.size()) != 0; i++) @(negedge clk);
    chk("drain_pending", qa.size() + qb.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  // output-ready pattern generator: 0 = hold low, 1 = hold high, 2 = random
  initial forever begin
    @(negedge clk);
    for (int s = 0; s < 2; s++) ordy[s] = (rmode[s] == 2) ? 1'($urandom_range(0, 1)) : (rmode[s] == 1);
  end

  // monitor: pop the scoreboard on every output handshake
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #1;
      for (int s = 0; s < 2; s++)
        if (reset_N && ov[s] && ordy[s]) begin
          if ((s == 0 ? qa.size() : qb.size()) == 0) chk(s == 0 ? "a_unexpected_out" : "b_unexpected_out", 1, 0);
          else begin
            if (s == 0) e = qa.pop_front();
            else e = qb.pop_front();
            chk(s == 0 ? "a_out_bit" : "b_out_bit", ob[s], e[1]);
            chk(s == 0 ? "a_out_last" : "b_out_last", ol[s], e[0]);
            if (s == 0) begin
              if (pp_first < 0) pp_first = cyc;
              pp_last = cyc;
            end
          end
        end
    end
  end

  initial begin
    logic [383:0] d, d1, d2, d3;
    iv = '{0, 0};
    ib = '{0, 0};
    ordy = '{0, 0};
    acc = '{0, 0};
    rmode = '{1, 1};
    #2 reset_N = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", ir[0], 0);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_last", ol[0], 0);
    chk("rst_out_bit", ob[0], 0);
    reset_N = 1;
    chk("in_ready_before_edge", ir[0], 0);
    @(negedge clk);
    chk("in_ready_after_release", ir[0], 1);
    chk("b_in_ready_after_release", ir[1], 1);

    d = '0;
    d[1] = 1'b1;
    send(0, d, 0, 0, NA);
    idle(0);
    for (int i = 0; i < 8 && !ov[0]; i++) @(negedge clk);
    chk("first_out_latency", cyc - last_fire_cyc, 1);
    drain();
    send(1, d, 0, 0, NB);
    idle(1);
    drain();

    pp_first = -1;
    d1 = rand384();
    d2 = rand384();
    d3 = rand384();
    send(0, d1, 0, 0, NA);
    send(0, d2, 0, 0, NA);
    send(0, d3, 0, 0, NA);
    idle(0);
    drain();
    chk("pingpong_span", pp_last - pp_first, 3 * NA - 1);

    rmode[0] = 0;
    acc[0] = 0;
    d1 = rand384();
    d2 = rand384();
    d3 = rand384();
    fork
      begin
        send(0, d1, 0, 0, NA);
        send(0, d2, 0, 0, NA);
        send(0, d3, 0, 0, NA);
        idle(0);
      end
    join_none
    repeat (2 * NA + 50) @(negedge clk);
    chk("bp_accepted", acc[0], 2 * NA);
    chk("bp_in_ready", ir[0], 0);
    chk("bp_out_valid", ov[0], 1);
    rmode[0] = 1;
    wait fork;
    drain();

    rmode = '{2, 2};
    for (int b = 0; b < 2; b++) begin
      fork
        begin send(0, rand384(), 30, 0, NA); idle(0); end
        begin send(1, rand384(), 30, 0, NB); idle(1); end
      join
    end
    drain();
    rmode = '{1, 1};

`ifdef INTERLEAVER_BYPASS_EN
    send(0, rand384(), 10, 1, NA);
    send(0, rand384(), 0, 0, NA);
    idle(0);
    drain();
`endif

    rmode[0] = 0;
    send(0, rand384(), 0, 0, NA);
    send(0, rand384(), 0, 0, 100);
    @(negedge clk);
    chk("pre_reset_out_valid", ov[0], 1);
    reset_N = 0;
    #1;
    chk("midreset_out_valid", ov[0], 0);
    chk("midreset_in_ready", ir[0], 0);
    chk("midreset_out_last", ol[0], 0);
    chk("midreset_out_bit", ob[0], 0);
    qa.delete();
    qb.delete();
    iv = '{0, 0};
    @(negedge clk);
    reset_N = 1;
    rmode[0] = 1;
    send(0, rand384(), 0, 0, NA);
    idle(0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wimax_interleaver_pp.md
Name: wimax_interleaver_pp

Overview:
- Parametrised IEEE 802.16 block interleaver with ping-pong buffering.
- Sits between the FEC encoder and the modulator in the 100 MHz domain.
- Accepts one coded bit per cycle and emits each interleaved block in sequential read order while the next block is written.
- Generalises the fixed 192-bit QPSK-1/2 interleaver to any N_CBPS, D and S, with valid/ready handshakes on both sides.

Parameters:
- N_CBPS, 192, coded bits per block; must be divisible by D and by S.
- D, 16, interleaver column count; power of two.
- S, 1, max(Nbpsc/2,1): 1=BPSK/QPSK, 2=16-QAM, 3 is not supported. S must be 1, 2 or 4 (power of two).
- AW, $clog2(N_CBPS), address/counter width (derived).

Ports:
- clk  in  1  100 MHz clock
- reset_N  in  1  asynchronous active-low reset
- in_valid  in  1  in_bit is valid this cycle
- in_ready  out  1  block accepts in_bit this cycle
- in_bit  in  1  coded input bit, block order k=0..N_CBPS-1
- out_valid  out  1  out_bit is valid
- out_ready  in  1  downstream accepts out_bit
- out_bit  out  1  interleaved bit, j=0..N_CBPS-1
- out_last  out  1  high with bit j=N_CBPS-1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_N.
- Reset values: in_ready=0 (rises the cycle after reset release), out_valid=0, out_last=0, out_bit=0. Both banks are EMPTY and all counters are 0.
- Storage: two banks of N_CBPS bits, B0 and B1.
- Each bank has a state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - Owns wr_bank, which starts at B0.
  - in_ready=1 when wr_bank is EMPTY or FILLING.
  - Transfer occurs when in_valid&in_ready. The bit is stored at the permuted address jk.
- Permutation. Counters col = k mod D and row = k/D are kept incrementally; no multiplier.
  - mk = (N_CBPS/D)*col + row. mk is a register: on each transfer add N_CBPS/D; when col wraps to 0, load mk = row+1.
  - jk = S*floor(mk/S) + ((mk + N_CBPS - col) mod S).
  - With S a power of two this is mk with its low log2(S) bits replaced by the low bits of (mk - col). For S=1, jk=mk.
- Write completion: after transfer k=N_CBPS-1 the bank goes FULL, wr_bank toggles and the counters clear.
- Read side:
  - Owns rd_bank, which starts at B0.
  - out_valid is registered and rises the cycle after rd_bank becomes FULL, so first-out latency is 1 cycle after the last input transfer.
  - out_bit = bank[rd_bank][rd_addr]. rd_addr advances on out_valid&out_ready.
  - At rd_addr=N_CBPS-1 with a transfer, the bank goes EMPTY, rd_bank toggles and rd_addr=0.
  - If the other bank is already FULL, out_valid stays high with no bubble.
- Throughput: one bit per cycle sustained when out_ready is held high.
- Backpressure: with both banks FULL/DRAINING, in_ready=0.
- Bits not handed over (in_valid=0 or out_ready=0) are held indefinitely with no loss.
- Simultaneous events: a bank finishing its drain and the write side finishing a fill in the same cycle are both honoured; the freed bank is writable on the next cycle.
- Reset mid-block: any partial block and any FULL blocks are discarded. No partial output is emitted.

Optional Feature:
- Macro: INTERLEAVER_BYPASS_EN.
- With the macro defined, a port bypass (in, 1) is added.
  - bypass is sampled at block start (k=0) and held for that block.
  - When set, the write address is k (identity), so output order equals input order.
  - Latency and handshakes are unchanged.
- Without the macro, there is no port and the permutation is always applied.

Decomposition:
- Package_wimax: INTERLEAVER_INPUT and INTERLEAVER_OUTPUT vectors, the 384-bit 16-QAM vectors, and a bank_state_t enum (EMPTY, FILLING, FULL, DRAINING).
- Sub-module intlv_addr_gen: the col/row/mk/jk counter, with inputs start/advance and output wr_addr. It is reusable by a future deinterleaver.

Test Plan:
- Basic QPSK vector, default params: INTERLEAVER_INPUT 192'h2833E48D…48CA driven MSB-first (bit191 as k=0), out_ready=1. Output MSB-first must equal 192'h4B047DFA…BD1E. out_last must pulse once, and out_valid must rise 1 cycle after the 192nd input.
- Single-one placement: S=1, input with only k=1 set -> only j=12 set. S=2, N_CBPS=384, only k=1 set -> only j=25 set.
- Ping-pong: three QPSK blocks back-to-back with in_valid=1 and out_ready=1. Expect 576 output bits with no gaps after the first latency, and each block matches.
- Backpressure: out_ready=0 during the second and third blocks. in_ready must drop after 384 accepted bits; after out_ready=1 the output is still correct and no bits are lost.
- Mid-block reset: assert reset_N=0 at k=100. Outputs go to reset values immediately; the next full block matches the expected output.
- Bypass (INTERLEAVER_BYPASS_EN): bypass=1 at k=0. Output equals the input 192'h2833…48CA.
